// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the program loader
package program_loader_pkg;

    // Architectural register / bus word
    typedef logic [31:0] arch_reg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } loader_state_t;

    // Header is one little-endian 32-bit word count
    localparam int LOADER_HDR_BYTES = 4;

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in, imem/dmem setup port out
//   byte_valid/byte_data/byte_ready : upstream byte stream, transfer on valid && ready
//   setup_write/address/data_in     : 1-cycle write strobe with held address and data
//   master = stream source / setup sink, slave = program_loader
interface program_loader_if;
    import program_loader_pkg::*;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       setup_write;
    arch_reg    setup_address;
    arch_reg    setup_data_in;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, setup_write, setup_address, setup_data_in
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, setup_write, setup_address, setup_data_in
    );

endinterface

// File: rtl/program_loader_word_assembler.sv
// rtl/program_loader_word_assembler.sv - packs accepted bytes into little-endian 32-bit words
//   clock, reset   : clock, async active-low reset
//   clear          : drop any partial word (new load)
//   byte_en        : a byte is transferred this cycle
//   byte_data      : the transferred byte
//   word           : assembled word, valid only while word_valid is high
//   word_valid     : high in the cycle the fourth byte of a word is transferred
module program_loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       byte_en,
    input  logic [7:0] byte_data,
    output arch_reg    word,
    output logic       word_valid
);

    localparam logic [1:0] LAST_IDX = 2'(LOADER_HDR_BYTES - 1);

    logic [1:0]  byte_idx;
    // Only the first three bytes need storage; the fourth is taken straight
    // from the input so the word is available in the cycle it completes.
    logic [23:0] partial;

    assign word       = {byte_data, partial};
    assign word_valid = byte_en && (byte_idx == LAST_IDX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_idx <= '0;
            partial  <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            partial  <= '0;
        end else if (byte_en) begin
            byte_idx <= byte_idx + 2'd1;
            partial  <= {byte_data, partial[23:8]};
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a length-prefixed byte image into the setup port, then releases the core
//   clock, reset   : clock, async active-low reset
//   start          : 1-cycle pulse, begins a load from S_IDLE/S_DONE/S_ERR
//   bus            : byte stream in, setup write port out (program_loader_if.slave)
//   core_run       : high in S_DONE only
//   busy           : high in S_LEN and S_DATA
//   error          : high in S_ERR (header count of zero or above MAX_WORDS)
//   words_loaded   : words written during the current load
module program_loader
    import program_loader_pkg::*;
#(
    parameter arch_reg BASE_ADDR = 32'h0000_0000,
    parameter int      MAX_WORDS = 1024
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    program_loader_if.slave                bus,
    output logic                           core_run,
    output logic                           busy,
    output logic                           error,
    output logic [$clog2(MAX_WORDS+1)-1:0] words_loaded
);

    localparam int W = $clog2(MAX_WORDS + 1);

    loader_state_t state;
    logic [W-1:0]  n_words;
    logic          accept;
    logic          start_ok;
    logic          hdr_bad;
    logic          word_valid;
    arch_reg       word;

    assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign accept   = bus.byte_valid && bus.byte_ready;
    assign hdr_bad  = (word == '0) || (word > arch_reg'(MAX_WORDS));

    // words_loaded advances at the same edge that raises the strobe, so once
    // the last word has been captured it equals n_words and further bytes are
    // refused while the final strobe is on the bus.
    assign bus.byte_ready = (state == S_LEN) ||
                            (state == S_DATA && words_loaded != n_words);

    assign core_run = (state == S_DONE);
    assign busy     = (state == S_LEN) || (state == S_DATA);
    assign error    = (state == S_ERR);

    program_loader_word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (start_ok),
        .byte_en    (accept),
        .byte_data  (bus.byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            n_words           <= '0;
            words_loaded      <= '0;
            bus.setup_write   <= 1'b0;
            bus.setup_address <= '0;
            bus.setup_data_in <= '0;
        end else begin
            bus.setup_write <= 1'b0;
            case (state)
                S_LEN: begin
                    if (word_valid) begin
                        if (hdr_bad) begin
                            state <= S_ERR;
                        end else begin
                            state   <= S_DATA;
                            n_words <= word[W-1:0];
                        end
                    end
                end
                S_DATA: begin
                    // Staging register: the completed word goes out on the
                    // next cycle while the next word's bytes keep arriving.
                    if (word_valid) begin
                        bus.setup_write   <= 1'b1;
                        bus.setup_address <= BASE_ADDR + (arch_reg'(words_loaded) << 2);
                        bus.setup_data_in <= word;
                        words_loaded      <= words_loaded + W'(1);
                    end
                    if (bus.setup_write && words_loaded == n_words) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    if (start_ok) begin
                        state        <= S_LEN;
                        words_loaded <= '0;
                    end
                end
            endcase
        end
    end

endmodule
